gfmult_arbiter: RTL and testbench

GFMULT_ARBITER -- requirements
Module: gfmult_arbiter

---
 rtl/gfmult_arbiter_pkg.sv | 31 +++
 rtl/gfmult_arbiter_mult.sv | 36 +++
 rtl/gfmult_arbiter.sv | 90 +++++++++
 tb/tb_gfmult_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gfmult_arbiter_pkg.sv
// Shared constants and types for the GF(2^5) multiply arbiter.
// Field is GF(2^5) generated by p(x) = x^5 + x^2 + 1.
package gfmult_arbiter_pkg;

    localparam int GF_WIDTH = 5;
    localparam int NUM_REQ  = 4;
    localparam int REQ_ID_W = 2;

    // Low-order terms of p(x); the implicit x^5 term is restored where needed.
    localparam logic [GF_WIDTH-1:0] GF_POLY = 5'b00101;

    // Full-width carry-less product of two field elements.
    localparam int PROD_W = 2 * GF_WIDTH - 1;

    typedef logic [GF_WIDTH-1:0] gf_elem_t;
    typedef logic [REQ_ID_W-1:0] req_id_t;
    typedef logic [NUM_REQ-1:0]  req_vec_t;

    // Result bundle handed from the multiply path to the output registers.
    typedef struct packed {
        logic     valid;
        req_id_t  id;
        gf_elem_t value;
    } gf_result_t;

    // Full reduction polynomial including the x^5 term.
    function automatic logic [GF_WIDTH:0] gf_poly_full();
        return {1'b1, GF_POLY};
    endfunction

endpackage

// File: rtl/gfmult_arbiter_mult.sv
// Combinational GF(2^5) multiplier: carry-less product, then
// polynomial reduction of the high-order terms from the top down.
import gfmult_arbiter_pkg::*;

module gf32_mult (
    input  logic [GF_WIDTH-1:0] in1,
    input  logic [GF_WIDTH-1:0] in2,
    output logic [GF_WIDTH-1:0] out
);

    logic [PROD_W-1:0] clmul;
    logic [PROD_W-1:0] reduced;

    // Carry-less (XOR) multiply of in1 by in2.
    always_comb begin
        clmul = '0;
        for (int i = 0; i < GF_WIDTH; i++) begin
            if (in2[i]) begin
                clmul = clmul ^ (PROD_W'(in1) << i);
            end
        end
    end

    // Fold each term of degree >= 5 back using p(x), highest first.
    always_comb begin
        reduced = clmul;
        for (int k = PROD_W - 1; k >= GF_WIDTH; k--) begin
            if (reduced[k]) begin
                reduced = reduced ^ (PROD_W'(gf_poly_full()) << (k - GF_WIDTH));
            end
        end
    end

    assign out = reduced[GF_WIDTH-1:0];

endmodule

// File: rtl/gfmult_arbiter.sv
// Round-robin arbiter in front of a single shared GF(2^5) multiplier.
// Grant is combinational; the product is registered one cycle later.
import gfmult_arbiter_pkg::*;

module gfmult_arbiter (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_REQ-1:0]  req,
    input  logic [GF_WIDTH-1:0] opa0,
    input  logic [GF_WIDTH-1:0] opa1,
    input  logic [GF_WIDTH-1:0] opa2,
    input  logic [GF_WIDTH-1:0] opa3,
    input  logic [GF_WIDTH-1:0] opb0,
    input  logic [GF_WIDTH-1:0] opb1,
    input  logic [GF_WIDTH-1:0] opb2,
    input  logic [GF_WIDTH-1:0] opb3,
    input  logic                stall,
    output logic [NUM_REQ-1:0]  gnt,
    output logic [GF_WIDTH-1:0] result,
    output logic                result_valid,
    output logic [REQ_ID_W-1:0] result_id
);

    req_id_t    ptr;
    req_id_t    sel_id;
    logic       sel_any;
    logic       issue;
    gf_elem_t   opa_arr [NUM_REQ];
    gf_elem_t   opb_arr [NUM_REQ];
    gf_elem_t   mul_a;
    gf_elem_t   mul_b;
    gf_elem_t   mul_y;
    gf_result_t res_q;

    assign opa_arr[0] = opa0;
    assign opa_arr[1] = opa1;
    assign opa_arr[2] = opa2;
    assign opa_arr[3] = opa3;
    assign opb_arr[0] = opb0;
    assign opb_arr[1] = opb1;
    assign opb_arr[2] = opb2;
    assign opb_arr[3] = opb3;

    // Find the first requester at or above ptr, wrapping; the scan runs
    // from the farthest offset down so the nearest one wins.
    always_comb begin
        sel_id  = '0;
        sel_any = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[ptr + req_id_t'(k)]) begin
                sel_any = 1'b1;
                sel_id  = ptr + req_id_t'(k);
            end
        end
    end

    assign issue = sel_any && !stall && !reset;
    assign gnt   = issue ? (req_vec_t'(1) << sel_id) : '0;

    assign mul_a = opa_arr[sel_id];
    assign mul_b = opb_arr[sel_id];

    gf32_mult u_mult (
        .in1 (mul_a),
        .in2 (mul_b),
        .out (mul_y)
    );

    // Output registers and pointer: load on grant, hold on stall.
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr   <= '0;
            res_q <= '0;
        end else if (!stall) begin
            if (issue) begin
                res_q.valid <= 1'b1;
                res_q.id    <= sel_id;
                res_q.value <= mul_y;
                ptr         <= sel_id + req_id_t'(1);
            end else begin
                res_q.valid <= 1'b0;
            end
        end
    end

    assign result       = res_q.value;
    assign result_valid = res_q.valid;
    assign result_id    = res_q.id;

endmodule

// File: tb/tb_gfmult_arbiter.sv
// Directed and randomized checks for gfmult_arbiter, plus an
// exhaustive standalone check of gf32_mult.
module tb_gfmult_arbiter;

    logic       clock;
    logic       reset;
    logic [3:0] req;
    logic [4:0] opa [4];
    logic [4:0] opb [4];
    logic       stall;
    logic [3:0] gnt;
    logic [4:0] result;
    logic       result_valid;
    logic [1:0] result_id;

    logic [4:0] m_a;
    logic [4:0] m_b;
    logic [4:0] m_y;

    int checks;
    int failures;

    gfmult_arbiter dut (
        .clock        (clock),
        .reset        (reset),
        .req          (req),
        .opa0         (opa[0]),
        .opa1         (opa[1]),
        .opa2         (opa[2]),
        .opa3         (opa[3]),
        .opb0         (opb[0]),
        .opb1         (opb[1]),
        .opb2         (opb[2]),
        .opb3         (opb[3]),
        .stall        (stall),
        .gnt          (gnt),
        .result       (result),
        .result_valid (result_valid),
        .result_id    (result_id)
    );

    gf32_mult u_mul (
        .in1 (m_a),
        .in2 (m_b),
        .out (m_y)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Multiply by repeated doubling (xtime) in GF(2^5), p(x)=x^5+x^2+1.
    function automatic logic [4:0] gf_ref(input logic [4:0] a, input logic [4:0] b);
        logic [4:0] r;
        logic [4:0] aa;
        r  = 5'h00;
        aa = a;
        for (int i = 0; i < 5; i++) begin
            if (b[i]) r = r ^ aa;
            aa = {aa[3:0], 1'b0} ^ (aa[4] ? 5'h05 : 5'h00);
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [1:0] id,
                             input logic [4:0] r);
        check({tag, "_valid"}, 8'(result_valid), 8'(v));
        check({tag, "_id"}, 8'(result_id), 8'(id));
        check({tag, "_result"}, 8'(result), 8'(r));
    endtask

    int         mptr;
    int         midx;
    logic       mfound;
    logic [3:0] mgnt;
    logic       exp_valid;
    logic [1:0] exp_id;
    logic [4:0] exp_res;
    int         wcnt [4];

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        stall    = 1'b0;
        req      = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            opa[i] = 5'h01;
            opb[i] = 5'h01;
        end
        m_a = 5'h00;
        m_b = 5'h00;

        // Reset state, with requests present.
        tick();
        tick();
        check("rst_gnt", 8'(gnt), 8'h0);
        check_out("rst", 1'b0, 2'd0, 5'h00);

        // Single requester 0: 2*2 = 4.
        reset  = 1'b0;
        req    = 4'b0001;
        opa[0] = 5'h02;
        opb[0] = 5'h02;
        #1 check("r0_gnt", 8'(gnt), 8'h1);
        tick();
        check_out("r0", 1'b1, 2'd0, 5'h04);
        req = 4'b0000;
        #1 check("idle_gnt", 8'(gnt), 8'h0);
        tick();
        check_out("idle", 1'b0, 2'd0, 5'h04);

        // Four requesters rotate 0,1,2,3,0,..; operand b=1 is identity.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req   = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            opa[i] = 5'(i + 1);
            opb[i] = 5'h01;
        end
        for (int i = 0; i < 8; i++) begin
            #1 check("rr_gnt", 8'(gnt), 8'(4'b0001 << (i % 4)));
            tick();
            check_out("rr", 1'b1, 2'(i % 4), 5'(i % 4 + 1));
        end

        // Stall freezes outputs and suppresses grants.
        req   = 4'b1010;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 check("stall_gnt", 8'(gnt), 8'h0);
            tick();
            check_out("stall", 1'b1, 2'd3, 5'h04);
        end
        stall = 1'b0;
        #1 check("post_stall_gnt1", 8'(gnt), 8'h2);
        tick();
        check_out("post_stall1", 1'b1, 2'd1, 5'h02);
        #1 check("post_stall_gnt3", 8'(gnt), 8'h8);
        tick();
        check_out("post_stall3", 1'b1, 2'd3, 5'h04);
        req = 4'b0000;
        tick();
        check("drain_valid", 8'(result_valid), 8'h0);

        // Pending result discarded by reset; pointer restarts at 0.
        req    = 4'b0100;
        opa[2] = 5'h03;
        opb[2] = 5'h03;
        #1 check("pre_rst_gnt", 8'(gnt), 8'h4);
        tick();
        check_out("pre_rst", 1'b1, 2'd2, 5'h05);
        reset = 1'b1;
        req   = 4'b1010;
        #1 check("mid_rst_gnt", 8'(gnt), 8'h0);
        tick();
        check_out("mid_rst", 1'b0, 2'd0, 5'h00);
        reset = 1'b0;
        #1 check("after_rst_gnt", 8'(gnt), 8'h2);
        tick();
        check_out("after_rst", 1'b1, 2'd1, 5'h02);

        // Zero operand, then operand changes after the grant are ignored.
        req    = 4'b0001;
        opa[0] = 5'h00;
        opb[0] = 5'h1b;
        #1 check("zero_gnt", 8'(gnt), 8'h1);
        tick();
        check_out("zero", 1'b1, 2'd0, 5'h00);
        req    = 4'b0000;
        opa[0] = 5'h1f;
        opb[0] = 5'h1f;
        tick();
        check_out("hold", 1'b0, 2'd0, 5'h00);

        // Reduction cases: x^4*x = x^2+1, x^4*x^4 = x^3+x^2+1.
        req    = 4'b0100;
        opa[2] = 5'h10;
        opb[2] = 5'h02;
        #1 check("red1_gnt", 8'(gnt), 8'h4);
        tick();
        check_out("red1", 1'b1, 2'd2, 5'h05);
        opa[2] = 5'h10;
        opb[2] = 5'h10;
        #1 check("red2_gnt", 8'(gnt), 8'h4);
        tick();
        check_out("red2", 1'b1, 2'd2, 5'h0D);
        req = 4'b0000;

        // Exhaustive standalone multiplier check.
        for (int a = 0; a < 32; a++) begin
            for (int b = 0; b < 32; b++) begin
                m_a = 5'(a);
                m_b = 5'(b);
                #1 check("mult", 8'(m_y), 8'(gf_ref(5'(a), 5'(b))));
            end
        end

        // Randomized traffic against a small arbiter model.
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        mptr      = 0;
        exp_valid = 1'b0;
        exp_id    = 2'd0;
        exp_res   = 5'h00;
        for (int i = 0; i < 4; i++) wcnt[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (req[i]) begin
                    if ($urandom_range(0, 19) == 0) req[i] = 1'b0;
                end else if ($urandom_range(0, 1) == 1) begin
                    req[i] = 1'b1;
                end
                opa[i] = 5'($urandom);
                opb[i] = 5'($urandom);
                if (!req[i]) wcnt[i] = 0;
            end
            stall = ($urandom_range(0, 4) == 0);
            #1;
            mfound = 1'b0;
            midx   = 0;
            for (int k = 0; k < 4; k++) begin
                if (!mfound && req[(mptr + k) % 4]) begin
                    mfound = 1'b1;
                    midx   = (mptr + k) % 4;
                end
            end
            mgnt = (mfound && !stall) ? 4'(4'b0001 << midx) : 4'b0000;
            check("rnd_gnt", 8'(gnt), 8'(mgnt));
            if (!stall) begin
                if (mfound) begin
                    check("rnd_wait_le3", 8'(wcnt[midx] <= 3), 8'h1);
                    for (int i = 0; i < 4; i++) begin
                        if (req[i] && i != midx) wcnt[i]++;
                    end
                    wcnt[midx] = 0;
                    exp_valid  = 1'b1;
                    exp_id     = 2'(midx);
                    exp_res    = gf_ref(opa[midx], opb[midx]);
                    mptr       = (midx + 1) % 4;
                end else begin
                    exp_valid = 1'b0;
                end
            end
            tick();
            check_out("rnd", exp_valid, exp_id, exp_res);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
